// File: rtl/bp_pht_ctrl_if.sv
// -----------------------------------------------------------------------------
// bp_pht_ctrl_if
// Bundles the lookup and update handshakes of the pattern-history-table
// controller.
//   master : front-end / resolve side (drives requests and updates)
//   slave  : bp_pht_ctrl (drives ready, response)
// Signals:
//   req_valid/req_idx/req_ready     lookup request handshake
//   resp_valid/resp_taken/resp_ctr  lookup result, one cycle after acceptance
//   upd_valid/upd_idx/upd_taken/upd_ready  resolved-branch update handshake
// -----------------------------------------------------------------------------
interface bp_pht_ctrl_if #(
    parameter int IDX_W = 6
) ();
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_taken;
    logic [1:0]       resp_ctr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;

    modport master (
        output req_valid, req_idx, upd_valid, upd_idx, upd_taken,
        input  req_ready, resp_valid, resp_taken, resp_ctr, upd_ready
    );

    modport slave (
        input  req_valid, req_idx, upd_valid, upd_idx, upd_taken,
        output req_ready, resp_valid, resp_taken, resp_ctr, upd_ready
    );
endinterface

// File: rtl/bp_pht_ctrl.sv
// -----------------------------------------------------------------------------
// bp_pht_ctrl
// Controller for a single-ported table of 2^IDX_W two-bit saturating branch
// counters. After reset or flush it sweeps every entry to INIT_CTR; in RUN it
// performs one table access per cycle: a queue drain when the update queue is
// full, otherwise a lookup if requested, otherwise a drain if anything is
// queued. Lookups see the table as it stands (no forwarding from the queue).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous; discards queued updates and restarts the sweep
//   bus        bp_pht_ctrl_if.slave: lookup request/response, update handshake
//   init_done  high while in RUN
// -----------------------------------------------------------------------------
module bp_pht_ctrl #(
    parameter int         IDX_W    = 6,
    parameter int         UQ_DEPTH = 4,
    parameter logic [1:0] INIT_CTR = 2'b11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    bp_pht_ctrl_if.slave  bus,
    output logic          init_done
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(UQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UQ_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_idx;

    logic [1:0]       pht      [ENTRIES];
    logic [IDX_W-1:0] uq_idx   [UQ_DEPTH];
    logic             uq_taken [UQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             resp_vld_p1;
    logic [1:0]       resp_ctr_p1;

    logic             run;
    logic             q_full;
    logic             q_empty;
    logic             do_lookup;
    logic             do_drain;
    logic             do_enq;
    logic [IDX_W-1:0] drain_idx;
    logic [1:0]       drain_val;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

    assign run     = (state == ST_RUN);
    assign q_full  = (count == FULL_CNT);
    assign q_empty = (count == '0);

    // One table access per cycle: a full queue pre-empts lookups so updates
    // cannot be starved forever by a continuous request stream.
    assign do_lookup = run && !q_full && bus.req_valid;
    assign do_drain  = run && (q_full || (!bus.req_valid && !q_empty));
    assign do_enq    = run && !q_full && bus.upd_valid;

    assign drain_idx = uq_idx[head];
    assign drain_val = sat_update(pht[drain_idx], uq_taken[head]);

    assign bus.req_ready  = run && !q_full;
    assign bus.upd_ready  = run && !q_full;
    assign bus.resp_valid = resp_vld_p1;
    assign bus.resp_ctr   = resp_ctr_p1;
    assign bus.resp_taken = resp_ctr_p1[1];
    assign init_done      = run;

    // Control state: FSM, sweep pointer, queue pointers, lookup response (p1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sweep_idx   <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            resp_vld_p1 <= 1'b0;
            resp_ctr_p1 <= 2'b00;
        end else begin
            // A lookup accepted in a flush cycle still returns its result.
            resp_vld_p1 <= do_lookup;
            if (do_lookup)
                resp_ctr_p1 <= pht[bus.req_idx];

            if (flush) begin
                state     <= ST_INIT;
                sweep_idx <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end else begin
                if (state == ST_INIT) begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == LAST_IDX)
                        state <= ST_RUN;
                end
                if (do_enq)
                    tail <= tail + PTR_W'(1);
                if (do_drain)
                    head <= head + PTR_W'(1);
                count <= count + CNT_W'(do_enq) - CNT_W'(do_drain);
            end
        end
    end

    // Table storage: sweep write during INIT, read-modify-write drain in RUN
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            pht[sweep_idx] <= INIT_CTR;
        else if (do_drain)
            pht[drain_idx] <= drain_val;
    end

    // Update-queue storage
    always_ff @(posedge clk) begin
        if (do_enq) begin
            uq_idx[tail]   <= bus.upd_idx;
            uq_taken[tail] <= bus.upd_taken;
        end
    end

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_pht_ctrl
// Scoreboard bench for bp_pht_ctrl. The driver applies inputs on the falling
// edge and advances a behavioural model (counter array plus a queue of pending
// resolutions); accepted lookups push their expected counter value and arrival
// cycle into a scoreboard queue, which an independent monitor pops whenever the
// DUT raises resp_valid.
// -----------------------------------------------------------------------------
module tb_bp_pht_ctrl;
    localparam int IDX_W    = 6;
    localparam int UQ_DEPTH = 4;
    localparam int ENTRIES  = 1 << IDX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic init_done;

    bp_pht_ctrl_if #(.IDX_W(IDX_W)) bus ();

    bp_pht_ctrl #(
        .IDX_W    (IDX_W),
        .UQ_DEPTH (UQ_DEPTH),
        .INIT_CTR (2'b11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s at cycle %0d: actual %0d expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    typedef struct {
        int ctr;
        int cyc;
    } exp_t;

    int   m_pht [ENTRIES];
    upd_t m_q[$];
    bit   m_run;
    int   m_init_left;
    exp_t exp_q[$];

    function automatic void model_init();
        for (int i = 0; i < ENTRIES; i++) m_pht[i] = 3;
        m_q.delete();
        m_run       = 1'b0;
        m_init_left = ENTRIES;
    endfunction

    function automatic int apply_outcome(input int c, input bit taken);
        if (taken) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic bit model_ready();
        return m_run && (m_q.size() < UQ_DEPTH);
    endfunction

    // Apply one cycle of inputs at a falling edge, check handshake outputs,
    // advance the model, then move on to the next falling edge.
    task automatic step(input bit rv, input int ridx, input bit uv, input int uidx,
                        input bit ut, input bit fl);
        bit   rdy;
        upd_t u;
        bus.req_valid = rv;
        bus.req_idx   = ridx[IDX_W-1:0];
        bus.upd_valid = uv;
        bus.upd_idx   = uidx[IDX_W-1:0];
        bus.upd_taken = ut;
        flush         = fl;
        rdy = model_ready();
        chk("req_ready", int'(bus.req_ready), int'(rdy));
        chk("upd_ready", int'(bus.upd_ready), int'(rdy));
        chk("init_done", int'(init_done), int'(m_run));
        if (rdy && rv) exp_q.push_back('{m_pht[ridx], cyc + 1});
        if (m_run) begin
            if (m_q.size() == UQ_DEPTH || (!rv && m_q.size() > 0)) begin
                u = m_q.pop_front();
                m_pht[u.idx] = apply_outcome(m_pht[u.idx], u.taken);
            end
            if (uv && rdy) m_q.push_back('{uidx, ut});
        end else begin
            m_init_left--;
            if (m_init_left == 0) m_run = 1'b1;
        end
        if (fl) model_init();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain_queue();
        int guard = 0;
        while (m_q.size() > 0 && guard < 50) begin
            step(0, 0, 0, 0, 0, 0);
            guard++;
        end
        chk("queue_drain_bound", m_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  int'(bus.req_ready),  0);
        chk({tag, "_upd_ready"},  int'(bus.upd_ready),  0);
        chk({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
        chk({tag, "_resp_taken"}, int'(bus.resp_taken), 0);
        chk({tag, "_resp_ctr"},   int'(bus.resp_ctr),   0);
        chk({tag, "_init_done"},  int'(init_done),      0);
    endtask

    // Called at a falling edge: optionally issue a lookup, then assert reset
    // shortly after the next rising edge so the response must be squashed.
    task automatic mid_reset(input bit rv, input int ridx);
        bus.req_valid = rv;
        bus.req_idx   = ridx[IDX_W-1:0];
        bus.upd_valid = 1'b0;
        flush         = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        model_init();
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_latency", cyc, mon_e.cyc);
                    chk("resp_ctr", int'(bus.resp_ctr), mon_e.ctr);
                    chk("resp_taken", int'(bus.resp_taken), int'(mon_e.ctr >= 2));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("resp_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int guard;
        bit rdy;

        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_init();

        // Init sweep, then lookup of entry 0
        idle(ENTRIES);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        // Saturation toward not-taken, then back toward taken
        for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 0, 0);
        idle(3);
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        idle(3);
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 5, 1, 0);
        step(0, 0, 1, 5, 1, 0);
        idle(3);
        step(1, 5, 0, 0, 0, 0);
        idle(2);

        // Back-to-back updates under continuous lookups: full-queue stall
        accepted = 0;
        guard    = 0;
        while (accepted < 5 && guard < 40) begin
            rdy = model_ready();
            step(1, $urandom_range(0, ENTRIES - 1), 1, 20 + accepted, accepted[0], 0);
            if (rdy) accepted++;
            guard++;
        end
        chk("five_updates_accepted", accepted, 5);
        drain_queue();
        for (int i = 20; i < 25; i++) step(1, i, 0, 0, 0, 0);
        idle(2);

        // Same-cycle update and lookup to idx 9: stale value, then updated
        step(1, 9, 1, 9, 0, 0);
        drain_queue();
        step(1, 9, 0, 0, 0, 0);
        idle(2);

        // Flush with three queued updates, then read the whole table back
        for (int i = 0; i < 3; i++) step(1, 40, 1, 30 + i, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(ENTRIES);
        for (int i = 0; i < ENTRIES; i++) step(1, i, 0, 0, 0, 0);
        idle(2);

        // Reset mid-sweep, then mid-lookup
        step(0, 0, 0, 0, 0, 1);
        idle(20);
        mid_reset(0, 0);
        idle(ENTRIES);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 0, 0);
        drain_queue();
        mid_reset(1, 7);
        idle(ENTRIES);
        step(1, 7, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic on a small index range to force collisions
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 7),
                 $urandom_range(0, 1), ($urandom_range(0, 599) == 0));
        end
        guard = 0;
        while (!m_run && guard < ENTRIES + 2) begin
            step(0, 0, 0, 0, 0, 0);
            guard++;
        end
        drain_queue();
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0, 0);
        idle(3);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
